peridot_spislave_bridge: RTL and testbench

- SPI responder (mode 0, MSB first) that lets an external SPI host read and write a small 32-bit register window inside the FPGA.
- It is the target-side counterpart of the host bridge's SPI initiator.
- Fabric side is a simple register bus with fixed 1-cycle read latency; typical use is mailbox/CSR access from a companion MCU.
- SCLK, SS_n and MOSI are oversampled in csi_clk.

---
 rtl/peridot_spislave_pkg.sv | 22 ++
 rtl/peridot_spislave_bridge_if.sv | 28 ++
 rtl/peridot_spislave_sync.sv | 56 +++++
 rtl/peridot_spislave_bridge.sv | 169 ++++++++++++++++
 tb/tb_peridot_spislave_bridge.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/peridot_spislave_pkg.sv
// Shared state encoding and framing constants for the SPI-slave register bridge.
package peridot_spislave_pkg;

   typedef enum logic [2:0] {
      ST_WAITHI,
      ST_IDLE,
      ST_CMD,
      ST_RDUMMY,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_t;

   localparam int CMD_RW_BIT = 7;
   localparam int CMD_BITS   = 8;
   localparam int DATA_BITS  = 32;
   localparam int SPI_MODE   = 0;

   localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
   localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);

endpackage

// File: rtl/peridot_spislave_bridge_if.sv
// Fabric-side register bus: the bridge is master, the register file is slave.
interface peridot_spislave_bridge_if #(
   parameter int ADDR_WIDTH = 3
) ();

   logic [ADDR_WIDTH-1:0] reg_address;
   logic                  reg_read;
   logic [31:0]           reg_readdata;
   logic                  reg_write;
   logic [31:0]           reg_writedata;

   modport master (
      output reg_address,
      output reg_read,
      input  reg_readdata,
      output reg_write,
      output reg_writedata
   );

   modport slave (
      input  reg_address,
      input  reg_read,
      output reg_readdata,
      input  reg_write,
      input  reg_writedata
   );

endinterface

// File: rtl/peridot_spislave_sync.sv
// Two-flop synchronisers for the SPI pins followed by a one-flop edge detector.
module peridot_spislave_sync
   import peridot_spislave_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ss_n,
   input  logic sclk,
   input  logic mosi,
   output logic ss_n_s,
   output logic mosi_s,
   output logic rise,
   output logic fall,
   output logic ss_rise,
   output logic ss_fall
);

   logic [1:0] ss_n_pipe;
   logic [1:0] sclk_pipe;
   logic [1:0] mosi_pipe;
   logic       ss_n_d;
   logic       sclk_d;
   logic       sclk_s;
   logic       sclk_up;
   logic       sclk_dn;

   // ss_n resets low so a frame already in progress at reset release is never seen as a new select edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_n_pipe <= '0;
         sclk_pipe <= '0;
         mosi_pipe <= '0;
         ss_n_d    <= 1'b0;
         sclk_d    <= 1'b0;
      end else begin
         ss_n_pipe <= {ss_n_pipe[0], ss_n};
         sclk_pipe <= {sclk_pipe[0], sclk};
         mosi_pipe <= {mosi_pipe[0], mosi};
         ss_n_d    <= ss_n_pipe[1];
         sclk_d    <= sclk_pipe[1];
      end
   end

   localparam bit SAMPLE_ON_UP = (SPI_MODE == 0) || (SPI_MODE == 3);

   assign ss_n_s  = ss_n_pipe[1];
   assign sclk_s  = sclk_pipe[1];
   assign mosi_s  = mosi_pipe[1];
   assign sclk_up = sclk_s & ~sclk_d;
   assign sclk_dn = ~sclk_s & sclk_d;
   assign rise    = ~ss_n_s & (SAMPLE_ON_UP ? sclk_up : sclk_dn);
   assign fall    = ~ss_n_s & (SAMPLE_ON_UP ? sclk_dn : sclk_up);
   assign ss_rise = ss_n_s & ~ss_n_d;
   assign ss_fall = ~ss_n_s & ss_n_d;

endmodule

// File: rtl/peridot_spislave_bridge.sv
// SPI mode-0 responder giving an external host read/write access to a 32-bit register window.
module peridot_spislave_bridge
   import peridot_spislave_pkg::*;
#(
   parameter int         REG_ADDR_WIDTH = 3,
   parameter logic [7:0] SYNC_BYTE      = 8'h5A
) (
   input  logic csi_clk,
   input  logic rsi_reset_n,
   input  logic coe_ss_n,
   input  logic coe_sclk,
   input  logic coe_mosi,
   output logic coe_miso,
   output logic coe_miso_oe,
   output logic busy,
   peridot_spislave_bridge_if.master reg_bus
);

   state_t                    state;
   state_t                    next_state;
   logic                      ss_n_s;
   logic                      mosi_s;
   logic                      rise;
   logic                      fall;
   logic                      ss_rise;
   logic                      ss_fall;
   logic [4:0]                bit_cnt;
   logic [DATA_BITS-2:0]      shift_in;
   logic [DATA_BITS-1:0]      shift_out;
   logic [DATA_BITS-1:0]      hold;
   logic [DATA_BITS-1:0]      writedata_q;
   logic [REG_ADDR_WIDTH-1:0] addr;
   logic [REG_ADDR_WIDTH-1:0] address_q;
   logic                      read_q;
   logic                      write_q;
   logic                      rd_pend;
   logic                      miso_q;
   logic [7:0]                cmd;
   logic [REG_ADDR_WIDTH-1:0] cmd_addr;
   logic                      cmd_reserved;
   logic                      byte_done;
   logic                      word_done;

   peridot_spislave_sync u_sync (
      .clk     (csi_clk),
      .rst_n   (rsi_reset_n),
      .ss_n    (coe_ss_n),
      .sclk    (coe_sclk),
      .mosi    (coe_mosi),
      .ss_n_s  (ss_n_s),
      .mosi_s  (mosi_s),
      .rise    (rise),
      .fall    (fall),
      .ss_rise (ss_rise),
      .ss_fall (ss_fall)
   );

   assign cmd          = {shift_in[6:0], mosi_s};
   assign cmd_addr     = cmd[REG_ADDR_WIDTH-1:0];
   assign cmd_reserved = |(cmd[6:0] >> REG_ADDR_WIDTH);
   assign byte_done    = rise && (bit_cnt == CMD_LAST);
   assign word_done    = rise && (bit_cnt == DATA_LAST);

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) state <= ST_WAITHI;
      else              state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (ss_rise) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_WAITHI: if (ss_n_s)    next_state = ST_IDLE;
            ST_IDLE:   if (ss_fall)   next_state = ST_CMD;
            ST_CMD:    if (byte_done) next_state = cmd_reserved      ? ST_IGNORE :
                                                   cmd[CMD_RW_BIT]   ? ST_RDUMMY : ST_WDATA;
            ST_RDUMMY: if (byte_done) next_state = ST_RDATA;
            ST_RDATA:  if (word_done) next_state = ST_IGNORE;
            default:   ;
         endcase
      end
   end

   // The read strobe fires with the command decode; its data lands in hold two clocks later regardless of frame state.
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         bit_cnt     <= '0;
         shift_in    <= '0;
         shift_out   <= '0;
         hold        <= '0;
         writedata_q <= '0;
         addr        <= '0;
         address_q   <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         rd_pend     <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
         rd_pend <= read_q;
         if (rd_pend) hold <= reg_bus.reg_readdata;
         case (state)
            ST_IDLE: begin
               if (ss_fall) begin
                  bit_cnt <= '0;
                  miso_q  <= 1'b0;
               end
            end
            ST_CMD: begin
               if (rise) begin
                  shift_in <= {shift_in[DATA_BITS-3:0], mosi_s};
                  bit_cnt  <= byte_done ? 5'd0 : bit_cnt + 5'd1;
               end
               if (byte_done && !cmd_reserved) begin
                  if (cmd[CMD_RW_BIT]) begin
                     read_q    <= 1'b1;
                     address_q <= cmd_addr;
                     shift_out <= {SYNC_BYTE, {(DATA_BITS-8){1'b0}}};
                  end else begin
                     addr <= cmd_addr;
                  end
               end
            end
            ST_RDUMMY, ST_RDATA: begin
               if (fall) begin
                  miso_q    <= shift_out[DATA_BITS-1];
                  shift_out <= {shift_out[DATA_BITS-2:0], 1'b0};
               end
               if (rise) begin
                  if (state == ST_RDUMMY) begin
                     bit_cnt <= byte_done ? 5'd0 : bit_cnt + 5'd1;
                     if (byte_done) shift_out <= hold;
                  end else begin
                     bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
                  end
               end
            end
            ST_WDATA: begin
               if (rise) begin
                  shift_in <= {shift_in[DATA_BITS-3:0], mosi_s};
                  bit_cnt  <= word_done ? 5'd0 : bit_cnt + 5'd1;
               end
               if (word_done) begin
                  write_q     <= 1'b1;
                  writedata_q <= {shift_in, mosi_s};
                  address_q   <= addr;
                  addr        <= addr + 1'b1;
               end
            end
            ST_IGNORE: begin
               if (fall) miso_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign coe_miso              = miso_q;
   assign coe_miso_oe           = ~ss_n_s && (state != ST_WAITHI);
   assign busy                  = (state != ST_IDLE) && (state != ST_WAITHI);
   assign reg_bus.reg_address   = address_q;
   assign reg_bus.reg_read      = read_q;
   assign reg_bus.reg_write     = write_q;
   assign reg_bus.reg_writedata = writedata_q;

endmodule

// File: tb/tb_peridot_spislave_bridge.sv
// Bench for peridot_spislave_bridge: SPI host driver, register-file slave, frame-level reference model and strobe scoreboard.
module tb_peridot_spislave_bridge;

   localparam int         HALF = 50;
   localparam logic [7:0] SYNC = 8'h5A;

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] data;
   } bus_event_t;

   logic csi_clk     = 1'b0;
   logic rsi_reset_n = 1'b0;
   logic coe_ss_n    = 1'b1;
   logic coe_sclk    = 1'b0;
   logic coe_mosi    = 1'b0;
   logic coe_miso;
   logic coe_miso_oe;
   logic busy;

   int tests  = 0;
   int failed = 0;

   bus_event_t  exp_q[$];
   logic [31:0] slave_mem [0:7] = '{default: 32'h0};
   logic [31:0] ref_mem   [0:7] = '{default: 32'h0};
   logic [31:0] tx_words  [0:3];
   logic        exp_bits  [0:135];

   peridot_spislave_bridge_if #(.ADDR_WIDTH(3)) bus ();

   peridot_spislave_bridge #(
      .REG_ADDR_WIDTH (3),
      .SYNC_BYTE      (8'h5A)
   ) dut (
      .csi_clk     (csi_clk),
      .rsi_reset_n (rsi_reset_n),
      .coe_ss_n    (coe_ss_n),
      .coe_sclk    (coe_sclk),
      .coe_mosi    (coe_mosi),
      .coe_miso    (coe_miso),
      .coe_miso_oe (coe_miso_oe),
      .busy        (busy),
      .reg_bus     (bus)
   );

   always #5 csi_clk = ~csi_clk;

   always @(posedge csi_clk) begin
      if (bus.reg_write) slave_mem[bus.reg_address] <= bus.reg_writedata;
      if (bus.reg_read)  bus.reg_readdata <= slave_mem[bus.reg_address];
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Every strobe the DUT raises must match the oldest outstanding expectation.
   bus_event_t mon_ev;
   always @(negedge csi_clk) begin
      if (bus.reg_read || bus.reg_write) begin
         if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("[TB] FAIL unexpected_strobe: got read=%0b write=%0b addr=%0d, expected no strobe",
                     bus.reg_read, bus.reg_write, bus.reg_address);
         end else begin
            mon_ev = exp_q.pop_front();
            check_output("strobe_kind", {30'h0, bus.reg_write, bus.reg_read}, mon_ev.wr ? 32'd2 : 32'd1);
            check_output("strobe_addr", {29'h0, bus.reg_address}, {29'h0, mon_ev.addr});
            if (mon_ev.wr) check_output("write_data", bus.reg_writedata, mon_ev.data);
         end
      end
   end

   task automatic model_frame(input logic [7:0] cmd, input int ndata);
      bus_event_t  e;
      logic [31:0] rd;
      logic [7:0]  sb;
      int          base;
      base = int'(cmd[2:0]);
      sb   = SYNC;
      for (int i = 0; i < 136; i++) exp_bits[i] = 1'b0;
      if (cmd[6:3] != 4'd0) return;
      if (cmd[7]) begin
         e.wr = 1'b0; e.addr = cmd[2:0]; e.data = 32'h0;
         exp_q.push_back(e);
         rd = ref_mem[base];
         for (int j = 0; j < 8; j++)  exp_bits[8 + j]  = sb[7 - j];
         for (int j = 0; j < 32; j++) exp_bits[16 + j] = rd[31 - j];
      end else begin
         for (int w = 0; w < ndata / 32; w++) begin
            e.wr = 1'b1; e.addr = 3'((base + w) % 8); e.data = tx_words[w];
            exp_q.push_back(e);
            ref_mem[(base + w) % 8] = tx_words[w];
         end
      end
   endtask

   task automatic spi_bit(input logic b, output logic m);
      coe_mosi = b;
      #HALF;
      m        = coe_miso;
      coe_sclk = 1'b1;
      #HALF;
      coe_sclk = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      logic m;
      for (int i = 0; i < n; i++) spi_bit(v[31 - i], m);
   endtask

   task automatic apply_stimulus(input logic [7:0] cmd, input int ndata);
      logic       m;
      logic       b;
      logic [7:0] got;
      logic [7:0] eb;
      int         j;
      model_frame(cmd, ndata);
      got = 8'h0;
      @(negedge csi_clk);
      coe_ss_n = 1'b0;
      repeat (6) @(negedge csi_clk);
      for (int i = 0; i < 8 + ndata; i++) begin
         if (i < 8) begin
            b = cmd[7 - i];
         end else begin
            j = i - 8;
            b = tx_words[j / 32][31 - (j % 32)];
         end
         spi_bit(b, m);
         got = {got[6:0], m};
         if (i % 8 == 7) begin
            for (int k = 0; k < 8; k++) eb[7 - k] = exp_bits[(i / 8) * 8 + k];
            check_output($sformatf("miso_byte%0d_cmd%02h", i / 8, cmd), {24'h0, got}, {24'h0, eb});
         end
         if (i == 4) begin
            check_output("miso_oe_in_frame", {31'h0, coe_miso_oe}, 32'd1);
            check_output("busy_in_frame", {31'h0, busy}, 32'd1);
         end
      end
      #HALF;
      coe_ss_n = 1'b1;
      repeat (5) @(negedge csi_clk);
      check_output("busy_after_frame", {31'h0, busy}, 32'd0);
      check_output("miso_oe_after_frame", {31'h0, coe_miso_oe}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_miso"}, {31'h0, coe_miso}, 32'd0);
      check_output({tag, "_miso_oe"}, {31'h0, coe_miso_oe}, 32'd0);
      check_output({tag, "_reg_read"}, {31'h0, bus.reg_read}, 32'd0);
      check_output({tag, "_reg_write"}, {31'h0, bus.reg_write}, 32'd0);
      check_output({tag, "_reg_address"}, {29'h0, bus.reg_address}, 32'd0);
      check_output({tag, "_reg_writedata"}, bus.reg_writedata, 32'd0);
      check_output({tag, "_busy"}, {31'h0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] c;
      int         nd;
      int         sel;

      repeat (3) @(negedge csi_clk);
      check_reset_values("por");
      rsi_reset_n = 1'b1;
      repeat (6) @(negedge csi_clk);

      tx_words[0] = 32'hDEADBEEF;
      apply_stimulus(8'h03, 32);

      tx_words[0] = 32'h11111111;
      tx_words[1] = 32'h22222222;
      apply_stimulus(8'h07, 64);

      tx_words[0] = 32'hCAFE1234;
      apply_stimulus(8'h05, 32);
      apply_stimulus(8'h85, 40);

      tx_words[0] = 32'h12345678;
      apply_stimulus(8'h02, 20);
      tx_words[0] = 32'h00000001;
      apply_stimulus(8'h02, 32);

      tx_words[0] = $urandom;
      apply_stimulus(8'h48, 32);

      // Reset lands mid-write; the rest of that frame must be ignored.
      @(negedge csi_clk);
      coe_ss_n = 1'b0;
      repeat (6) @(negedge csi_clk);
      send_bits({8'h02, 24'h0}, 8);
      send_bits(32'hFFFFFFFF, 10);
      rsi_reset_n = 1'b0;
      repeat (2) @(negedge csi_clk);
      check_reset_values("mid");
      rsi_reset_n = 1'b1;
      send_bits(32'hFFFFFFFF, 22);
      check_output("busy_ignored_frame", {31'h0, busy}, 32'd0);
      #HALF;
      coe_ss_n = 1'b1;
      repeat (6) @(negedge csi_clk);

      tx_words[0] = 32'hA5A5A5A5;
      apply_stimulus(8'h01, 32);
      apply_stimulus(8'h81, 40);
      apply_stimulus(8'h83, 40);

      for (int k = 0; k < 14; k++) begin
         sel = int'($urandom_range(0, 9));
         for (int w = 0; w < 4; w++) tx_words[w] = $urandom;
         if (sel == 0) begin
            c  = {1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 3'($urandom_range(0, 7))};
            nd = 32;
         end else if (sel < 4) begin
            c  = {1'b1, 4'b0, 3'($urandom_range(0, 7))};
            nd = 40;
         end else begin
            c  = {1'b0, 4'b0, 3'($urandom_range(0, 7))};
            nd = 32 * int'($urandom_range(1, 3));
            if (sel == 9) nd = nd - int'($urandom_range(1, 31));
         end
         apply_stimulus(c, nd);
      end

      repeat (10) @(negedge csi_clk);
      check_output("pending_strobes", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
